// File: rtl/vector_checker_pkg.sv
// vector_checker_pkg: shared types and default widths for the vector checker.
//   state_t   - run-control FSM states
//   DEF_*     - default parameter values for the top level
//   vec_t     - one stimulus/expected/mask record at default widths
package vector_checker_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  localparam int DEF_STIM_W  = 16;
  localparam int DEF_EXP_W   = 16;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_CNT_W   = 16;

  typedef struct packed {
    logic [DEF_STIM_W-1:0] stim;
    logic [DEF_EXP_W-1:0]  exp;
    logic [DEF_EXP_W-1:0]  mask;
  } vec_t;

endpackage

// File: rtl/vector_checker_sample_tick_gen.sv
// sample_tick_gen: divides the core clock down to the sample rate.
//   clk, rst  - core clock, async active-high reset
//   i_en      - count only while enabled
//   i_clr     - synchronous clear of the divider (takes priority)
//   o_tick    - one-cycle pulse when the divider reaches CLK_DIV-1
module sample_tick_gen #(
  parameter  int CLK_DIV = 4,
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;

  // With CLK_DIV=1 LAST is 0 and r_div never leaves 0, so the tick follows i_en.
  assign o_tick = i_en && (r_div == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_div <= '0;
    else if (i_clr)  r_div <= '0;
    else if (i_en)   r_div <= o_tick ? '0 : r_div + DIV_W'(1);
  end

endmodule

// File: rtl/vector_checker.sv
// vector_checker: RAM-backed test-vector sequencer and response checker.
//   clk, rst                 - core clock, async active-high reset
//   load_*                   - write one {stim, exp, mask} row (ignored while busy)
//   num_vectors, start       - vector count (latched on start) and run trigger
//   stim_data, stim_valid    - stimulus to the DUT, pulse per issued vector
//   dut_out                  - DUT response, sampled one sample period after issue
//   mismatch, error_count    - per-failure pulse and saturating failure count
//   test_passed, busy, done  - run status
//   vec_index                - index of the next vector to issue
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter  int STIM_W  = DEF_STIM_W,
  parameter  int EXP_W   = DEF_EXP_W,
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int CLK_DIV = DEF_CLK_DIV,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [STIM_W-1:0] load_stim,
  input  logic [EXP_W-1:0]  load_exp,
  input  logic [EXP_W-1:0]  load_mask,
  input  logic [ADDR_W:0]   num_vectors,
  input  logic              start,
  output logic [STIM_W-1:0] stim_data,
  output logic              stim_valid,
  input  logic [EXP_W-1:0]  dut_out,
  output logic              mismatch,
  output logic [CNT_W-1:0]  error_count,
  output logic              test_passed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   vec_index
);

  typedef struct packed {
    logic [STIM_W-1:0] stim;
    logic [EXP_W-1:0]  exp;
    logic [EXP_W-1:0]  mask;
  } row_t;

  row_t mem [DEPTH];
  row_t r_rd;

  state_t            r_state;
  logic [ADDR_W:0]   r_num;
  logic [ADDR_W:0]   r_vec_index;
  logic [STIM_W-1:0] r_stim_data;
  logic              r_stim_valid;
  logic [EXP_W-1:0]  r_cur_exp;
  logic [EXP_W-1:0]  r_cur_mask;
  logic              r_mismatch;
  logic [CNT_W-1:0]  r_err;
  logic              r_passed;
  logic              r_busy;
  logic              r_done;

  logic              w_run_st;
  logic              w_start_ok;
  logic              w_tick;
  logic              w_cmp;
  logic              w_fail;
  logic [ADDR_W:0]   w_next_idx;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_run_st   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_start_ok = start && !w_run_st;
  assign w_next_idx = r_vec_index + 1'b1;

  // The issued vector's exp/mask are held until the following tick, when the
  // DUT has had one full sample period to respond.
  assign w_fail = |((dut_out ^ r_cur_exp) & r_cur_mask);
  assign w_cmp  = w_tick && (((r_state == ST_RUN) && (r_vec_index != '0)) ||
                             (r_state == ST_DRAIN));

  // Address lookahead: r_rd always holds the row for r_vec_index, re-aimed at
  // the next index on the tick edge itself, so back-to-back ticks work.
  assign w_rd_addr = w_start_ok ? '0 :
                     w_tick     ? w_next_idx[ADDR_W-1:0] :
                                  r_vec_index[ADDR_W-1:0];

  sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_run_st),
    .i_clr  (w_start_ok),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (load_en && !w_run_st) mem[load_addr] <= {load_stim, load_exp, load_mask};
    r_rd <= mem[w_rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_num        <= '0;
      r_vec_index  <= '0;
      r_stim_data  <= '0;
      r_stim_valid <= 1'b0;
      r_cur_exp    <= '0;
      r_cur_mask   <= '0;
      r_mismatch   <= 1'b0;
      r_err        <= '0;
      r_passed     <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_stim_valid <= 1'b0;
      r_mismatch   <= 1'b0;
      if (w_cmp && w_fail) begin
        r_mismatch <= 1'b1;
        r_passed   <= 1'b0;
        if (r_err != '1) r_err <= r_err + 1'b1;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_num       <= num_vectors;
            r_vec_index <= '0;
            r_err       <= '0;
            r_passed    <= 1'b1;
            r_done      <= (num_vectors == '0);
            r_busy      <= (num_vectors != '0);
            r_state     <= (num_vectors == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_tick) begin
            r_stim_data  <= r_rd.stim;
            r_cur_exp    <= r_rd.exp;
            r_cur_mask   <= r_rd.mask;
            r_stim_valid <= 1'b1;
            r_vec_index  <= w_next_idx;
            if (w_next_idx == r_num) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_tick) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stim_data   = r_stim_data;
  assign stim_valid  = r_stim_valid;
  assign mismatch    = r_mismatch;
  assign error_count = r_err;
  assign test_passed = r_passed;
  assign busy        = r_busy;
  assign done        = r_done;
  assign vec_index   = r_vec_index;

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: two instances (CLK_DIV=4/CNT_W=16 and
// CLK_DIV=1/CNT_W=2) on a shared load bus. Each run is checked cycle by cycle
// against a timing/score model derived from tick k at cycle CLK_DIV*(k+1).
module tb_vector_checker;
  import vector_checker_pkg::*;

  logic        clk, rst;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [15:0] load_stim, load_exp, load_mask;
  logic [6:0]  num_vectors;
  logic        start_a, start_b;

  logic [15:0] a_data, b_data, a_dut, b_dut;
  logic        a_valid, b_valid, a_mm, b_mm, a_pass, b_pass;
  logic        a_busy, b_busy, a_done, b_done;
  logic [15:0] a_err;
  logic [1:0]  b_err;
  logic [6:0]  a_vi, b_vi;

  // DUT model: responds with stimulus + 1.
  assign a_dut = a_data + 16'd1;
  assign b_dut = b_data + 16'd1;

  vector_checker #(.DEPTH(64), .CLK_DIV(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
    .num_vectors(num_vectors), .start(start_a), .stim_data(a_data),
    .stim_valid(a_valid), .dut_out(a_dut), .mismatch(a_mm), .error_count(a_err),
    .test_passed(a_pass), .busy(a_busy), .done(a_done), .vec_index(a_vi));

  vector_checker #(.DEPTH(64), .CLK_DIV(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
    .num_vectors(num_vectors), .start(start_b), .stim_data(b_data),
    .stim_valid(b_valid), .dut_out(b_dut), .mismatch(b_mm), .error_count(b_err),
    .test_passed(b_pass), .busy(b_busy), .done(b_done), .vec_index(b_vi));

  logic        sel;
  logic [15:0] o_data, o_err;
  logic        o_valid, o_mm, o_pass, o_busy, o_done;
  logic [6:0]  o_vi;
  assign o_data  = sel ? b_data  : a_data;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_mm    = sel ? b_mm    : a_mm;
  assign o_err   = sel ? {14'd0, b_err} : a_err;
  assign o_pass  = sel ? b_pass  : a_pass;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_vi    = sel ? b_vi    : a_vi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] m_stim [64];
  logic [15:0] m_exp  [64];
  logic [15:0] m_mask [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, want);
    end
  endtask

  function automatic bit vfail(input int j);
    logic [15:0] r;
    r = m_stim[j] + 16'd1;
    return ((r ^ m_exp[j]) & m_mask[j]) != 16'd0;
  endfunction

  task automatic load(input int a, input vec_t v);
    @(negedge clk);
    load_en = 1'b1; load_addr = 6'(a);
    load_stim = v.stim; load_exp = v.exp; load_mask = v.mask;
    m_stim[a] = v.stim; m_exp[a] = v.exp; m_mask[a] = v.mask;
  endtask

  task automatic load_end;
    @(negedge clk); load_en = 1'b0;
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start_b = v; else start_a = v;
  endtask

  task automatic check_reset(input bit s);
    sel = s; #1;
    chk("rst_data", o_data, 0);  chk("rst_valid", o_valid, 0);
    chk("rst_mm", o_mm, 0);      chk("rst_err", o_err, 0);
    chk("rst_pass", o_pass, 1);  chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);  chk("rst_vi", o_vi, 0);
  endtask

  // One complete run; sample c is taken at the negedge after edge c
  // (edge 0 = the start edge). poke >= 0 re-pulses start mid-run.
  task automatic run(input bit s, input int n, input int poke);
    int d, maxe, fails, tot, q;
    bit issue, cmp, f;
    d = s ? 1 : 4; maxe = s ? 3 : 65535;
    sel = s; num_vectors = 7'(n);
    @(negedge clk); set_start(s, 1'b1);
    @(negedge clk); set_start(s, 1'b0);
    fails = 0; tot = d * (n + 1) + 2;
    for (int c = 0; c <= tot; c++) begin
      if (c > 0) @(negedge clk);
      q = c / d;
      issue = (n > 0) && (c > 0) && (c % d == 0) && (q >= 1) && (q <= n);
      cmp   = (n > 0) && (c > 0) && (c % d == 0) && (q >= 2) && (q <= n + 1);
      f = cmp && vfail(q - 2);
      if (f) fails++;
      chk("stim_valid", o_valid, issue);
      if (issue) chk("stim_data", o_data, m_stim[q - 1]);
      chk("mismatch", o_mm, f);
      chk("error_count", o_err, (fails > maxe) ? maxe : fails);
      chk("test_passed", o_pass, fails == 0);
      chk("done", o_done, (n == 0) || (c >= d * (n + 1)));
      chk("busy", o_busy, (n > 0) && (c < d * (n + 1)));
      chk("vec_index", o_vi, (n == 0) ? 0 : ((q > n) ? n : q));
      set_start(s, c == poke);
    end
    set_start(s, 1'b0);
  endtask

  typedef struct {
    bit   sel;
    int   n;
    int   poke;
    vec_t v [8];
    int   want_err;
    bit   want_pass;
  } tv_t;

  tv_t tv [7];

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_stim = '0; load_exp = '0;
    load_mask = '0; num_vectors = '0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_reset(1'b0);
    check_reset(1'b1);
    @(negedge clk); rst = 1'b0;

    // Scenario table: all-pass, single failure (+ ignored start), mask off/on,
    // saturation at CNT_W=2, clearing restart, empty run.
    for (int t = 0; t < 7; t++)
      for (int i = 0; i < 8; i++)
        tv[t].v[i] = '{stim: 16'(i + 1), exp: 16'(i + 2), mask: 16'hFFFF};
    tv[0].sel = 0; tv[0].n = 4; tv[0].poke = -1; tv[0].want_err = 0; tv[0].want_pass = 1;
    tv[1] = tv[0]; tv[1].poke = 10; tv[1].v[2].exp = 16'h0000;
    tv[1].want_err = 1; tv[1].want_pass = 0;
    tv[2] = tv[0]; tv[2].v[1] = '{stim: 16'hAB02, exp: 16'h00FF, mask: 16'h0000};
    tv[3] = tv[2]; tv[3].v[1].mask = 16'h00FF; tv[3].want_err = 1; tv[3].want_pass = 0;
    tv[4].sel = 1; tv[4].n = 6; tv[4].poke = -1; tv[4].want_err = 3; tv[4].want_pass = 0;
    for (int i = 0; i < 8; i++) tv[4].v[i].exp = 16'h5555;
    tv[5].sel = 1; tv[5].n = 1; tv[5].poke = -1; tv[5].want_err = 0; tv[5].want_pass = 1;
    tv[6].sel = 0; tv[6].n = 0; tv[6].poke = -1; tv[6].want_err = 0; tv[6].want_pass = 1;

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < tv[t].n; i++) load(i, tv[t].v[i]);
      load_end();
      run(tv[t].sel, tv[t].n, tv[t].poke);
      chk($sformatf("tv%0d_err", t), o_err, tv[t].want_err);
      chk($sformatf("tv%0d_pass", t), o_pass, tv[t].want_pass);
    end

    // Reset in the middle of an 8-vector run, then replay from the same RAM.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.stim = 16'(i * 3 + 7);
      v.exp  = (i == 0) ? 16'h0000 : v.stim + 16'd1;
      v.mask = 16'hFFFF;
      load(i, v);
    end
    load_end();
    sel = 0; num_vectors = 7'd8;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_rst_vi", o_vi, 3);
    chk("pre_rst_err", o_err, 1);
    rst = 1'b1;
    check_reset(1'b0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_vi", o_vi, 0);
    run(0, 8, -1);
    chk("replay_err", o_err, 1);

    // Randomized runs on both instances.
    for (int r = 0; r < 14; r++) begin
      bit s;
      int n, hi, poke;
      s = 1'($urandom_range(0, 1));
      n = s ? $urandom_range(1, 40) : $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        vec_t v;
        v.stim = 16'($urandom);
        v.exp  = ($urandom_range(0, 2) != 0) ? v.stim + 16'd1 : 16'($urandom);
        v.mask = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'($urandom);
        load(i, v);
      end
      load_end();
      hi = (s ? 1 : 4) * (n + 1) - 2;
      poke = (hi >= 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, hi) : -1;
      run(s, n, poke);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
